regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised multi-read-port register file; successor to the fixed 32x32, 2-read-port regfile.
//  Sits in the processor decode stage and feeds the ALU/branch operands.
//  Adds the following over the fixed version:
//   - N read ports.
//   - A hardware-owned input register, loaded by peripherals with a strobe.
//   - A mirrored output register.
//   - A one-register-per-cycle scrub sequencer that zeroes the file without reset.
// PARAMETERS
//  WIDTH       32  data width of every register
//  DEPTH       32  number of registers (power of 2, >=4); reg0 reads zero
//  AW          5   address width = clog2(DEPTH)
//  NUM_READ    2   number of combinational read ports
//  IO_IN_REG   20  index written only by hardware (io_in_*)
//  IO_OUT_REG  16  index whose content is mirrored on io_out
// PORTS
//  clock             in   1              rising-edge clock
//  ctrl_reset        in   1              async active-high reset
//  ctrl_writeEnable  in   1              CPU write request
//  ctrl_writeReg     in   AW             CPU write address
//  data_writeReg     in   WIDTH          CPU write data
//  ctrl_readReg      in   NUM_READ*AW    read addresses; port k = [k*AW +: AW]
//  data_readReg      out  NUM_READ*WIDTH read data; port k = [k*WIDTH +: WIDTH]
//  io_in_valid       in   1              peripheral strobe: load io_in_data into IO_IN_REG
//  io_in_data        in   WIDTH          peripheral data
//  io_out            out  WIDTH          current content of IO_OUT_REG (registered)
//  ctrl_scrub        in   1              one-cycle pulse: start zeroing the file
//  scrub_busy        out  1              high while the scrub sequencer is active
// BEHAVIOUR
//  Reset
//   - ctrl_reset high clears all registers to 0 asynchronously.
//   - FSM returns to IDLE; scrub_busy=0, io_out=0.
//   - Reset mid-scrub aborts the scrub immediately.
//  Reads
//   - Combinational and independent per port.
//   - Address 0 always returns 0.
//   - Any address >= DEPTH cannot occur (AW exact).
//  CPU write
//   - Register updates on the clock edge when ctrl_writeEnable=1 and scrub_busy=0.
//   - Writes to reg0 are ignored.
//   - Writes to IO_IN_REG are ignored; software treats it as read-only.
//   - Writes while scrub_busy=1 are dropped; the core stalls on scrub_busy.
//  IO input
//   - io_in_valid=1 loads io_in_data into IO_IN_REG at the edge.
//   - The load is ignored while the scrub is clearing IO_IN_REG in that same cycle.
//  io_out
//   - Equals the stored IO_OUT_REG value; no combinational path from data_writeReg.
//   - Updates the cycle after a write.
//  Scrub FSM
//   - States: IDLE, SCRUB.
//   - IDLE & ctrl_scrub -> SCRUB, with idx=1.
//   - In SCRUB, each edge zeroes reg[idx] and increments idx.
//   - At idx=DEPTH-1: zero that register, then go to IDLE.
//   - scrub_busy = (state==SCRUB): asserted the cycle after the pulse, for exactly DEPTH-1 cycles.
//   - ctrl_scrub while busy is ignored; the sequence does not restart.
//   - idx is AW bits; wrap to 0 never occurs because the FSM exits at DEPTH-1.
//  Simultaneous events, same cycle/register
//   - Priority: scrub > io_in > CPU write (CPU write to IO_IN_REG is already ignored).
// CONFIGURATION
//  BYPASS_EN
//   - Defined: a read port whose address equals ctrl_writeReg returns data_writeReg in the same cycle.
//   - Applies only when the write is accepted (enable=1, addr!=0, addr!=IO_IN_REG, not busy).
//   - Also, a read of IO_IN_REG while io_in_valid=1 (not being scrubbed) returns io_in_data.
//   - Not defined: reads always return stored contents; new data is visible the cycle after the write.
//   - No other behaviour differs.
// TESTING
//  1. Reset, then write 0xDEADBEEF to r5; next cycle read r5 on all ports -> 0xDEADBEEF.
//     Write 0x1234 to r0 -> r0 reads 0.
//  2. Write r16=0xA5A5A5A5 -> io_out=0xA5A5A5A5 one cycle later.
//     CPU write 0x77 to r20 -> r20 unchanged.
//  3. io_in_valid with io_in_data=0x00000042 -> r20 reads 0x42 next cycle.
//     Same cycle as a CPU write r20=0x99 -> r20=0x42.
//  4. Fill r1..r31 with the index; pulse ctrl_scrub.
//     -> scrub_busy high exactly 31 cycles; all registers read 0 afterwards.
//     A CPU write r3=7 issued mid-scrub is dropped (r3=0).
//     A second ctrl_scrub pulse mid-scrub does not extend busy.
//  5. Assert ctrl_reset asynchronously at scrub cycle 10 -> scrub_busy=0 and all regs=0 immediately.
//     Next CPU write r9=0x5 succeeds.
//  6. With BYPASS_EN: write r7=0xCAFE and read r7 in the same cycle -> 0xCAFE.
//     Without BYPASS_EN -> old value (0), then 0xCAFE next cycle.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register-file bus: CPU write port, N read ports, peripheral IO and scrub control.
interface regfile_param_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_READ = 2
);
  logic                         ctrl_writeEnable;
  logic [AW-1:0]                ctrl_writeReg;
  logic [WIDTH-1:0]             data_writeReg;
  logic [NUM_READ*AW-1:0]       ctrl_readReg;
  logic [NUM_READ*WIDTH-1:0]    data_readReg;
  logic                         io_in_valid;
  logic [WIDTH-1:0]             io_in_data;
  logic [WIDTH-1:0]             io_out;
  logic                         ctrl_scrub;
  logic                         scrub_busy;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    output io_in_valid, io_in_data, ctrl_scrub,
    input  data_readReg, io_out, scrub_busy
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    input  io_in_valid, io_in_data, ctrl_scrub,
    output data_readReg, io_out, scrub_busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with a hardware-owned input
// register, a mirrored output register and a one-register-per-cycle scrubber.
// Optional feature: define BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned IO_IN_REG  = 20,
  parameter int unsigned IO_OUT_REG = 16
) (
  input  logic            clock,
  input  logic            ctrl_reset,
  regfile_param_if.slave  bus
);

  typedef enum logic {IDLE, SCRUB} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             wr_acc_c;
  logic             io_acc_c;

  // Acceptance of CPU and peripheral writes this cycle
  always_comb begin
    wr_acc_c = bus.ctrl_writeEnable && !busy_q &&
               (bus.ctrl_writeReg != '0) &&
               (bus.ctrl_writeReg != AW'(IO_IN_REG));
    io_acc_c = bus.io_in_valid &&
               !((state_q == SCRUB) && (idx_q == AW'(IO_IN_REG)));
  end

  // Scrub sequencer next state: walk idx 1..DEPTH-1, one register per cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.ctrl_scrub) begin
          state_d = SCRUB;
          idx_d   = AW'(1);
        end
      end
      SCRUB: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d == SCRUB);
  end

  // Register array next value; later assignments win: scrub > io_in > CPU
  always_comb begin
    mem_d = mem_q;
    if (wr_acc_c) mem_d[bus.ctrl_writeReg] = bus.data_writeReg;
    if (io_acc_c) mem_d[IO_IN_REG] = bus.io_in_data;
    if (state_q == SCRUB) mem_d[idx_q] = '0;
  end

  // State, index and storage flops with asynchronous clear
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0]    addr_c;
    logic [WIDTH-1:0] data_c;

    // Combinational read port; address 0 is hard-wired to zero
    always_comb begin
      addr_c = bus.ctrl_readReg[k*AW +: AW];
      data_c = mem_q[addr_c];
`ifdef BYPASS_EN
      if (wr_acc_c && (addr_c == bus.ctrl_writeReg)) begin
        data_c = bus.data_writeReg;
      end else if (io_acc_c && (addr_c == AW'(IO_IN_REG))) begin
        data_c = bus.io_in_data;
      end
`endif
      if (addr_c == '0) data_c = '0;
    end

    assign bus.data_readReg[k*WIDTH +: WIDTH] = data_c;
  end

  assign bus.io_out     = mem_q[IO_OUT_REG];
  assign bus.scrub_busy = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the register file.
module tb_regfile_param;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int          IOIN  = 20;
  localparam int          IOOUT = 16;

  logic clock;
  logic ctrl_reset;

  regfile_param_if #(.WIDTH(W), .AW(AW), .NUM_READ(NR)) bus ();

  regfile_param #(
    .WIDTH(W), .DEPTH(DEPTH), .AW(AW), .NUM_READ(NR),
    .IO_IN_REG(IOIN), .IO_OUT_REG(IOOUT)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: register contents plus scrub position (0 = idle, else register to clear)
  logic [W-1:0] mdl [DEPTH];
  int           scrub_pos;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit wr_ok();
    int a;
    a = int'(bus.ctrl_writeReg);
    return bus.ctrl_writeEnable && (scrub_pos == 0) && (a != 0) && (a != IOIN);
  endfunction

  function automatic bit io_ok();
    return bus.io_in_valid && (scrub_pos != IOIN);
  endfunction

  function automatic logic [W-1:0] exp_rd(int a);
    if (a == 0) return '0;
`ifdef BYPASS_EN
    if (wr_ok() && a == int'(bus.ctrl_writeReg)) return bus.data_writeReg;
    if (io_ok() && a == IOIN) return bus.io_in_data;
`endif
    return mdl[a];
  endfunction

  function automatic logic [W-1:0] rd(int k);
    return bus.data_readReg[k*W +: W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    scrub_pos = 0;
  endtask

  // Advance one clock: compute model's next state from current inputs, then apply after the edge
  task automatic tick();
    logic [W-1:0] nxt [DEPTH];
    int np;
    nxt = mdl;
    np  = scrub_pos;
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
      np = 0;
    end else begin
      if (wr_ok()) nxt[int'(bus.ctrl_writeReg)] = bus.data_writeReg;
      if (io_ok()) nxt[IOIN] = bus.io_in_data;
      if (scrub_pos != 0) begin
        nxt[scrub_pos] = '0;
        np = (scrub_pos == DEPTH - 1) ? 0 : scrub_pos + 1;
      end else if (bus.ctrl_scrub) begin
        np = 1;
      end
    end
    @(posedge clock);
    #1;
    mdl       = nxt;
    scrub_pos = np;
  endtask

  task automatic drive_idle();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.io_in_valid      = 1'b0;
    bus.io_in_data       = '0;
    bus.ctrl_scrub       = 1'b0;
  endtask

  task automatic set_ra(int k, int a);
    bus.ctrl_readReg[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_ra_all(int a);
    for (int k = 0; k < NR; k++) set_ra(k, a);
  endtask

  task automatic set_write(int a, logic [W-1:0] d);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = AW'(a);
    bus.data_writeReg    = d;
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clock) begin
    if (chk_en && !ctrl_reset) begin
      check("busy", W'(bus.scrub_busy), W'(scrub_pos != 0));
      check("io_out", bus.io_out, mdl[IOOUT]);
      for (int k = 0; k < NR; k++)
        check($sformatf("rd%0d", k), rd(k),
              exp_rd(int'(bus.ctrl_readReg[k*AW +: AW])));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    ctrl_reset = 1'b1;
    drive_idle();
    set_ra_all(0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    set_ra_all(5);
    @(negedge clock);
    check("rst_busy", W'(bus.scrub_busy), W'(0));
    check("rst_io_out", bus.io_out, W'(0));
    check("rst_r5", rd(0), W'(0));
    tick();

    // Test 1: r5 write, r0 write ignored
    set_write(5, 32'hDEADBEEF);
    tick();
    drive_idle();
    set_ra_all(5);
    @(negedge clock);
    for (int k = 0; k < NR; k++) check($sformatf("t1_r5_p%0d", k), rd(k), 32'hDEADBEEF);
    tick();
    set_write(0, 32'h1234);
    tick();
    drive_idle();
    set_ra_all(0);
    @(negedge clock);
    check("t1_r0", rd(0), W'(0));
    tick();

    // Test 2: io_out mirror, CPU write to IO_IN_REG ignored
    set_write(16, 32'hA5A5A5A5);
    tick();
    drive_idle();
    @(negedge clock);
    check("t2_io_out", bus.io_out, 32'hA5A5A5A5);
    tick();
    set_write(20, 32'h77);
    tick();
    drive_idle();
    set_ra_all(20);
    @(negedge clock);
    check("t2_r20", rd(0), W'(0));
    tick();

    // Test 3: peripheral load, priority over CPU write
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = 32'h42;
    tick();
    drive_idle();
    @(negedge clock);
    check("t3_r20", rd(1), 32'h42);
    tick();
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = 32'h11;
    tick();
    bus.io_in_data  = 32'h42;
    set_write(20, 32'h99);
    tick();
    drive_idle();
    @(negedge clock);
    check("t3_r20_prio", rd(0), 32'h42);
    tick();

    // Test 4: fill, scrub, dropped write, ignored second pulse
    for (int a = 1; a < DEPTH; a++) begin
      set_write(a, W'(a));
      tick();
    end
    drive_idle();
    set_ra(0, 3);
    set_ra(1, 31);
    @(negedge clock);
    check("t4_fill_r3", rd(0), W'(3));
    check("t4_fill_r31", rd(1), W'(31));
    bus.ctrl_scrub = 1'b1;
    tick();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      drive_idle();
      if (c == 5) set_write(3, W'(7));
      if (c == 8) bus.ctrl_scrub = 1'b1;
      @(negedge clock);
      if (bus.scrub_busy) cnt++;
      tick();
    end
    check("t4_busy_cycles", W'(cnt), W'(31));
    drive_idle();
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int k = 0; k < NR; k++) set_ra(k, a + k);
      @(negedge clock);
      for (int k = 0; k < NR; k++) check($sformatf("t4_zero_r%0d", a + k), rd(k), W'(0));
      tick();
    end
    set_ra_all(3);
    @(negedge clock);
    check("t4_r3_dropped", rd(0), W'(0));
    tick();

    // Test 5: asynchronous reset mid-scrub
    for (int a = 1; a < DEPTH; a++) begin
      set_write(a, W'(a + 100));
      tick();
    end
    drive_idle();
    bus.ctrl_scrub = 1'b1;
    tick();
    drive_idle();
    repeat (10) tick();
    set_ra(0, 9);
    set_ra(1, 31);
    #1;
    check("t5_pre_r31", rd(1), W'(131));
    #1;
    ctrl_reset = 1'b1;
    model_reset();
    #1;
    check("t5_rst_busy", W'(bus.scrub_busy), W'(0));
    check("t5_rst_r9", rd(0), W'(0));
    check("t5_rst_r31", rd(1), W'(0));
    check("t5_rst_io_out", bus.io_out, W'(0));
    tick();
    ctrl_reset = 1'b0;
    set_write(9, W'(5));
    tick();
    drive_idle();
    @(negedge clock);
    check("t5_r9", rd(0), W'(5));
    tick();

    // Test 6: same-cycle read of a write
    set_ra(0, 7);
    set_write(7, 32'hCAFE);
    @(negedge clock);
`ifdef BYPASS_EN
    check("t6_same_cycle", rd(0), 32'hCAFE);
`else
    check("t6_same_cycle", rd(0), W'(0));
`endif
    tick();
    drive_idle();
    @(negedge clock);
    check("t6_next_cycle", rd(0), 32'hCAFE);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      int wa;
      wa = int'($urandom_range(DEPTH - 1));
      bus.ctrl_writeEnable = $urandom_range(1) == 1;
      bus.ctrl_writeReg    = AW'(wa);
      bus.data_writeReg    = $urandom;
      bus.io_in_valid      = $urandom_range(3) == 0;
      bus.io_in_data       = $urandom;
      bus.ctrl_scrub       = $urandom_range(79) == 0;
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(3))
          0: set_ra(k, wa);
          1: set_ra(k, IOIN);
          default: set_ra(k, int'($urandom_range(DEPTH - 1)));
        endcase
      end
      tick();
    end
    drive_idle();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
